note_player: RTL and testbench
==============================

Name: note_player

Overview:
- Consumer end of the note handshake driven by the song sequencer.
- Accepts {note, duration, activate} on a one-cycle new_note strobe and counts beats for that duration.
- Returns a one-cycle note_done pulse when the duration expires.
- While the note plays, advances a 20-bit phase accumulator by a per-note step on each sample request; the top 10 bits index the waveform/sine lookup downstream.

Parameters:
- PHASE_WIDTH, 20, phase accumulator width (bits)
- INDEX_WIDTH, 10, width of phase_index output (top bits of accumulator)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- play  input  1  global play enable; low freezes all progress
- new_note  input  1  one-cycle load strobe from sequencer
- note  input  6  note number; 0 = rest, 1..63 = pitch (49 = A4, 440 Hz)
- duration  input  6  note length in beats
- activate  input  1  effect/activate flag accompanying the note
- beat  input  1  one-cycle beat tick
- generate_next_sample  input  1  one-cycle request from the 48 kHz sample pipeline
- note_done  output  1  one-cycle pulse, duration expired
- phase_index  output  10  phase[19:10]
- sample_valid  output  1  one-cycle pulse, phase_index updated
- rest  output  1  current note is a rest (note==0) or player idle
- note_active  output  1  latched activate flag of current note

Behaviour:
- Clock is clk; reset is asynchronous and active-high. Reset forces:
  - state=IDLE; phase, counters and latched note/duration/activate to 0
  - note_done=0, sample_valid=0, rest=1, note_active=0, phase_index=0
- States: IDLE, PLAYING.
- Load:
  - new_note=1 in any state, with play=1: latch note, duration and activate; load beat_ctr=duration; clear phase to 0; next state PLAYING.
  - new_note with play=0 is ignored.
- PLAYING, play=1:
  - beat=1 decrements beat_ctr.
  - When beat_ctr==1 and beat=1, note_done is registered high for exactly the next cycle, and state goes to IDLE.
- Duration 0: after load, note_done pulses on the cycle after entry to PLAYING (beat not required), then IDLE.
- Sample generation: in PLAYING with play=1 and generate_next_sample=1:
  - note!=0: phase <= phase + step(note), mod 2^20 (wrap silently).
  - note==0: phase holds.
  - sample_valid is registered: one cycle after the request, in both cases.
- IDLE: generate_next_sample yields sample_valid with rest=1 and phase held.
- play=0: beat_ctr, phase and state frozen; note_done and sample_valid held at 0; beats and sample requests during pause are dropped, not queued.
- Simultaneous events:
  - new_note with beat in the same cycle: load wins, beat ignored.
  - new_note on the cycle beat_ctr would expire: load wins, no note_done for the old note.
  - beat with generate_next_sample in the same cycle: both are processed independently.
- Step table: step(n) = round(440 * 2^((n-49)/12) * 2^20 / 48000), 20-bit unsigned, with step(0)=0.
  - Anchors: step(1)=601, step(49)=9612, step(63)=21578.
- Outputs:
  - note_active = latched activate while PLAYING, else 0.
  - rest = (state==IDLE) || (latched note==0).
- Latency:
  - new_note to PLAYING: 1 cycle.
  - request to sample_valid: 1 cycle.
  - final beat to note_done: 1 cycle.

Decomposition:
- Shared package: NOTE_WIDTH=6, DURATION_WIDTH=6, PHASE_WIDTH=20, sample rate 48000, A4 note number 49, and the IDLE/PLAYING state encodings.
- Sub-module note_step_rom: combinational 64x20 lookup, note to step, generated from the formula above.
- Use the existing dffr flops for the state, beat_ctr and phase registers.

Test Plan:
1. Reset mid-note:
   - Load note 49, duration 4, then assert reset after 2 beats.
   - Required: all outputs at reset values immediately, with no note_done.
2. Load note 49, duration 3, then 3 beat pulses spaced 10 cycles apart.
   - Required: note_done high for exactly 1 cycle, the cycle after the 3rd beat.
   - Required: then IDLE, rest=1.
3. Load note 49, then 2 generate_next_sample pulses.
   - Required: sample_valid after each; phase = 9612 then 19224.
   - Required: phase_index = 9 then 18.
4. Rest and wrap:
   - Load note 0: sample requests give sample_valid, phase_index stays 0, rest=1.
   - Load note 63, issue 49 requests: phase = 49*21578 mod 2^20 = 8746, index 8.
5. Pause:
   - During a duration-2 note, drop play for 20 cycles with beats and sample requests pulsed.
   - Required: no change, no pulses; after play returns, 2 further beats give note_done.
6. Overlapping events:
   - new_note and beat in the same cycle: beat_ctr = new duration.
   - Duration 0: note_done pulses 2 cycles after the new_note strobe.

Source files
------------

// File: rtl/note_player_pkg.sv
// Shared constants, state encoding and pitch helpers for the note player
// and its step lookup.
package note_player_pkg;

  localparam int NOTE_WIDTH     = 6;
  localparam int DURATION_WIDTH = 6;
  localparam int STEP_WIDTH     = 20;
  localparam int SAMPLE_RATE    = 48000;
  localparam int A4_NOTE        = 49;
  localparam int A4_FREQ        = 440;

  typedef enum logic {
    IDLE    = 1'b0,
    PLAYING = 1'b1
  } state_t;

  // 2^(s/12) scaled by 1e10, for one octave of semitone offsets
  function automatic logic [63:0] semitone_ratio(input int s);
    case (s)
      0:       return 64'd10000000000;
      1:       return 64'd10594630944;
      2:       return 64'd11224620483;
      3:       return 64'd11892071150;
      4:       return 64'd12599210499;
      5:       return 64'd13348398542;
      6:       return 64'd14142135624;
      7:       return 64'd14983070769;
      8:       return 64'd15874010520;
      9:       return 64'd16817928305;
      10:      return 64'd17817974363;
      default: return 64'd18877486254;
    endcase
  endfunction

endpackage

// File: rtl/dffr.sv
// Plain register with asynchronous active-high clear.
module dffr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/note_player_step_rom.sv
// Combinational note-number to phase-step table, built from the equal-tempered
// pitch formula with A4 (note 49) at 440 Hz and a 48 kHz sample rate.
module note_player_step_rom
  import note_player_pkg::*;
(
  input  logic [NOTE_WIDTH-1:0] note,
  output logic [STEP_WIDTH-1:0] step
);

  // Note n sits (n-1)/12 octaves above note 1, which is four octaves below A4,
  // so the divisor starts 16x larger and halves once per octave.
  function automatic logic [STEP_WIDTH-1:0] calc_step(input int n);
    logic [63:0] num;
    logic [63:0] den;
    if (n == 0) return '0;
    num = 64'(A4_FREQ) * 64'(1 << STEP_WIDTH) * semitone_ratio((n - 1) % 12);
    den = (64'(SAMPLE_RATE) * 64'd10000000000 * 64'd16) >> ((n - 1) / 12);
    return STEP_WIDTH'((num + den / 2) / den);
  endfunction

  logic [STEP_WIDTH-1:0] rom [2**NOTE_WIDTH];

  for (genvar g = 0; g < 2**NOTE_WIDTH; g++) begin : gen_rom
    assign rom[g] = calc_step(g);
  end

  assign step = rom[note];

endmodule

// File: rtl/note_player.sv
// Plays one note at a time from the sequencer: counts beats for its duration,
// pulses note_done at the end, and advances the phase accumulator on sample requests.
module note_player
  import note_player_pkg::*;
#(
  parameter int PHASE_WIDTH = STEP_WIDTH,
  parameter int INDEX_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic                      new_note,
  input  logic [NOTE_WIDTH-1:0]     note,
  input  logic [DURATION_WIDTH-1:0] duration,
  input  logic                      activate,
  input  logic                      beat,
  input  logic                      generate_next_sample,
  output logic                      note_done,
  output logic [INDEX_WIDTH-1:0]    phase_index,
  output logic                      sample_valid,
  output logic                      rest,
  output logic                      note_active
);

  state_t                    state;
  state_t                    next_state;
  logic [0:0]                state_bits;
  logic [DURATION_WIDTH-1:0] beat_ctr;
  logic [DURATION_WIDTH-1:0] next_ctr;
  logic [PHASE_WIDTH-1:0]    phase;
  logic [PHASE_WIDTH-1:0]    next_phase;
  logic [NOTE_WIDTH-1:0]     note_q;
  logic                      activate_q;
  logic                      done_d;
  logic                      valid_d;
  logic [STEP_WIDTH-1:0]     step;

  note_player_step_rom u_step_rom (
    .note (note_q),
    .step (step)
  );

  dffr #(.WIDTH(1)) u_state_reg (
    .clk   (clk),
    .reset (reset),
    .d     (next_state),
    .q     (state_bits)
  );

  dffr #(.WIDTH(DURATION_WIDTH)) u_beat_ctr_reg (
    .clk   (clk),
    .reset (reset),
    .d     (next_ctr),
    .q     (beat_ctr)
  );

  dffr #(.WIDTH(PHASE_WIDTH)) u_phase_reg (
    .clk   (clk),
    .reset (reset),
    .d     (next_phase),
    .q     (phase)
  );

  assign state = state_t'(state_bits);

  // A load overrides everything else in its cycle; a zero-length note
  // finishes on its first PLAYING cycle without waiting for a beat.
  always_comb begin
    next_state = state;
    next_ctr   = beat_ctr;
    next_phase = phase;
    done_d     = 1'b0;
    valid_d    = 1'b0;
    if (play) begin
      valid_d = generate_next_sample;
      if (new_note) begin
        next_state = PLAYING;
        next_ctr   = duration;
        next_phase = '0;
      end else if (state == PLAYING) begin
        if (beat_ctr == '0) begin
          done_d     = 1'b1;
          next_state = IDLE;
        end else if (beat) begin
          next_ctr = beat_ctr - DURATION_WIDTH'(1);
          if (beat_ctr == DURATION_WIDTH'(1)) begin
            done_d     = 1'b1;
            next_state = IDLE;
          end
        end
        if (generate_next_sample && note_q != '0)
          next_phase = phase + PHASE_WIDTH'(step);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      note_q       <= '0;
      activate_q   <= 1'b0;
      note_done    <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      note_done    <= done_d;
      sample_valid <= valid_d;
      if (play && new_note) begin
        note_q     <= note;
        activate_q <= activate;
      end
    end
  end

  assign phase_index = phase[PHASE_WIDTH-1 -: INDEX_WIDTH];
  assign rest        = (state == IDLE) || (note_q == '0);
  assign note_active = (state == PLAYING) && activate_q;

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: a vector table, directed corner-case
// sequences, and randomized traffic checked against a pitch/beat reference model.
module tb_note_player;

  logic       clk = 1'b0;
  logic       reset;
  logic       play;
  logic       new_note;
  logic [5:0] note;
  logic [5:0] duration;
  logic       activate;
  logic       beat;
  logic       generate_next_sample;
  logic       note_done;
  logic [9:0] phase_index;
  logic       sample_valid;
  logic       rest;
  logic       note_active;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state, kept in plain integers
  bit m_playing;
  bit m_act;
  int m_note;
  int m_left;
  int m_phase;
  bit m_done;
  bit m_valid;

  typedef struct {
    bit       play;
    bit       nn;
    bit [5:0] note;
    bit [5:0] dur;
    bit       act;
    bit       beat;
    bit       gen;
    bit       e_done;
    bit       e_valid;
    bit       e_rest;
    bit       e_active;
    int       e_index;
  } vec_t;

  vec_t vecs [16];

  note_player dut (
    .clk                  (clk),
    .reset                (reset),
    .play                 (play),
    .new_note             (new_note),
    .note                 (note),
    .duration             (duration),
    .activate             (activate),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .note_done            (note_done),
    .phase_index          (phase_index),
    .sample_valid         (sample_valid),
    .rest                 (rest),
    .note_active          (note_active)
  );

  always #5 clk = ~clk;

  function automatic int ref_step(input int n);
    real f;
    if (n == 0) return 0;
    f = 440.0 * (2.0 ** ((n - 49) / 12.0)) * 1048576.0 / 48000.0;
    return $rtoi(f + 0.5);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit p, input bit nn, input int n, input int d,
                               input bit a, input bit b, input bit g);
    play                 = p;
    new_note             = nn;
    note                 = 6'(n);
    duration             = 6'(d);
    activate             = a;
    beat                 = b;
    generate_next_sample = g;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input bit e_done, input bit e_valid,
                             input bit e_rest, input bit e_active, input int e_index);
    logic [13:0] act_v;
    logic [13:0] exp_v;
    act_v = {note_done, sample_valid, rest, note_active, phase_index};
    exp_v = {e_done, e_valid, e_rest, e_active, 10'(e_index)};
    compared++;
    if (act_v !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL %s: got done=%b valid=%b rest=%b active=%b index=%0d, want done=%b valid=%b rest=%b active=%b index=%0d",
               name, note_done, sample_valid, rest, note_active, phase_index,
               e_done, e_valid, e_rest, e_active, e_index);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    idleInputs();
    tick();
    reset = 1'b0;
    tick();
    m_playing = 0; m_act = 0; m_note = 0; m_left = 0; m_phase = 0;
    m_done = 0; m_valid = 0;
  endtask

  // One cycle of the reference model, straight from the note-player rules
  task automatic modelCycle(input bit p, input bit nn, input int n, input int d,
                            input bit a, input bit b, input bit g);
    m_done  = 0;
    m_valid = 0;
    if (!p) return;
    m_valid = g;
    if (nn) begin
      m_playing = 1; m_note = n; m_act = a; m_left = d; m_phase = 0;
      return;
    end
    if (!m_playing) return;
    if (m_left == 0) begin
      m_done = 1; m_playing = 0;
    end else if (b) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1; m_playing = 0;
      end
    end
    if (g) m_phase = (m_phase + ref_step(m_note)) % (1 << 20);
  endtask

  initial begin
    reset = 1'b1;
    idleInputs();
    #1;
    checkOutput("reset_state", 0, 0, 1, 0, 0);
    tick();
    reset = 1'b0;
    tick();

    // ---------------- table-driven vectors ----------------
    vecs[0]  = '{1,1,49,2,1,0,0, 0,0,0,1,0};
    vecs[1]  = '{1,0, 0,0,0,0,1, 0,1,0,1,9};
    vecs[2]  = '{1,0, 0,0,0,0,0, 0,0,0,1,9};
    vecs[3]  = '{1,0, 0,0,0,1,1, 0,1,0,1,18};
    vecs[4]  = '{0,0, 0,0,0,1,1, 0,0,0,1,18};
    vecs[5]  = '{1,0, 0,0,0,1,0, 1,0,1,0,18};
    vecs[6]  = '{1,0, 0,0,0,0,0, 0,0,1,0,18};
    vecs[7]  = '{1,0, 0,0,0,0,1, 0,1,1,0,18};
    vecs[8]  = '{1,1, 0,1,0,0,0, 0,0,1,0,0};
    vecs[9]  = '{1,0, 0,0,0,0,1, 0,1,1,0,0};
    vecs[10] = '{0,1,49,3,1,0,0, 0,0,1,0,0};
    vecs[11] = '{1,1,49,3,1,1,0, 0,0,0,1,0};
    vecs[12] = '{1,0, 0,0,0,1,0, 0,0,0,1,0};
    vecs[13] = '{1,0, 0,0,0,1,0, 0,0,0,1,0};
    vecs[14] = '{1,0, 0,0,0,1,0, 1,0,1,0,0};
    vecs[15] = '{1,0, 0,0,0,0,1, 0,1,1,0,0};
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].play, vecs[i].nn, vecs[i].note, vecs[i].dur,
                    vecs[i].act, vecs[i].beat, vecs[i].gen);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].e_done, vecs[i].e_valid,
                  vecs[i].e_rest, vecs[i].e_active, vecs[i].e_index);
    end

    // ---------------- reset mid-note ----------------
    doReset();
    applyStimulus(1, 1, 49, 4, 1, 0, 0); tick();
    applyStimulus(1, 0, 0, 0, 0, 1, 1);  tick();
    applyStimulus(1, 0, 0, 0, 0, 1, 0);  tick();
    checkOutput("pre_reset", 0, 0, 0, 1, 9);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_note", 0, 0, 1, 0, 0);
    idleInputs();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 1, 0);
      tick();
      checkOutput("post_reset_quiet", 0, 0, 1, 0, 0);
    end

    // ---------------- wrap on note 63 ----------------
    doReset();
    applyStimulus(1, 1, 63, 10, 0, 0, 0); tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 49; i++) tick();
    checkOutput("wrap_note63", 0, 1, 0, 0, ((49 * ref_step(63)) % (1 << 20)) >> 10);

    // ---------------- pause ----------------
    doReset();
    applyStimulus(1, 1, 49, 2, 1, 0, 0); tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 1);  tick();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0, 0, (i % 3) == 0, (i % 2) == 0);
      tick();
      checkOutput("pause_frozen", 0, 0, 0, 1, 9);
    end
    applyStimulus(1, 0, 0, 0, 0, 1, 0); tick();
    checkOutput("resume_beat1", 0, 0, 0, 1, 9);
    applyStimulus(1, 0, 0, 0, 0, 1, 0); tick();
    checkOutput("resume_beat2", 1, 0, 1, 0, 9);
    idleInputs(); tick();
    checkOutput("resume_done_clear", 0, 0, 1, 0, 9);

    // ---------------- duration 0 ----------------
    doReset();
    applyStimulus(1, 1, 5, 0, 1, 0, 0); tick();
    idleInputs();
    checkOutput("dur0_entry", 0, 0, 0, 1, 0);
    tick();
    checkOutput("dur0_done", 1, 0, 1, 0, 0);
    tick();
    checkOutput("dur0_clear", 0, 0, 1, 0, 0);

    // ---------------- new_note on expiring beat ----------------
    doReset();
    applyStimulus(1, 1, 10, 1, 0, 0, 0); tick();
    applyStimulus(1, 1, 12, 2, 1, 1, 0); tick();
    checkOutput("reload_no_done", 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0); tick();
    checkOutput("reload_beat1", 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0); tick();
    checkOutput("reload_beat2", 1, 0, 1, 0, 0);

    // ---------------- randomized traffic vs model ----------------
    doReset();
    for (int i = 0; i < 3000; i++) begin
      bit p, nn, a, b, g;
      int n, d;
      p  = $urandom_range(0, 9) != 0;
      nn = $urandom_range(0, 15) == 0;
      n  = $urandom_range(0, 63);
      d  = $urandom_range(0, 7);
      a  = $urandom_range(0, 1) != 0;
      b  = $urandom_range(0, 2) == 0;
      g  = $urandom_range(0, 1) != 0;
      applyStimulus(p, nn, n, d, a, b, g);
      modelCycle(p, nn, n, d, a, b, g);
      tick();
      checkOutput($sformatf("random%0d", i), m_done, m_valid,
                  !m_playing || m_note == 0, m_playing && m_act, m_phase >> 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
